sprite_cmd_writer: RTL

SPRITE_CMD_WRITER -- requirements
Module: sprite_cmd_writer

---
 rtl/sprite_cmd_writer.sv | 108 ++++++++++
 1 files changed

// File: rtl/sprite_cmd_writer.sv
// Sprite command FIFO: buffers Avalon command writes and releases them to the PPU during vblank.
// Optional SPRITE_CMD_OVF_CNT_EN adds a saturating dropped-command counter on ovf_count.
module sprite_cmd_writer #(
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter int unsigned VBLANK_START = 480
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          chipselect,
    input  logic                          write,
    input  logic [31:0]                   writedata,
    input  logic [2:0]                    address,
    input  logic [9:0]                    hcount,
    input  logic [9:0]                    vcount,
    output logic                          ppu_write,
    output logic [31:0]                   ppu_writedata,
    output logic [2:0]                    ppu_address,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
`ifdef SPRITE_CMD_OVF_CNT_EN
    output logic [7:0]                    ovf_count,
`endif
    output logic                          overflow
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [9:0]  VblankLine = 10'(VBLANK_START);

    typedef enum logic [1:0] {StIdle, StDrain, StDone} state_e;

    state_e         state_q, state_d;
    logic [34:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]  count_q;
    logic           overflow_q;
    logic           ppu_write_q;
    logic [31:0]    ppu_writedata_q;
    logic [2:0]     ppu_address_q;
    logic           empty, full, push_req, push, pop, drop, blank_over;

    always_comb begin
        empty      = (count_q == '0);
        full       = (count_q == CW'(FIFO_DEPTH));
        push_req   = chipselect && write;
        pop        = (state_q == StDrain) && !empty;
        // A pop in the same cycle frees the slot, so a push into a full FIFO still succeeds.
        push       = push_req && (!full || pop);
        drop       = push_req && full && !pop;
        blank_over = (vcount < VblankLine);

        state_d = state_q;
        unique case (state_q)
            StIdle:  if (vcount == VblankLine && hcount == 10'd0) state_d = StDrain;
            StDrain: begin
                if (blank_over)           state_d = StIdle;
                else if (empty && !push)  state_d = StDone;
            end
            StDone:  if (blank_over) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Storage is not reset; occupancy is governed solely by the pointers and count.
    always_ff @(posedge clk) begin
        if (!reset && push) mem_q[wr_ptr_q] <= {address, writedata};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= StIdle;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            overflow_q      <= 1'b0;
            ppu_write_q     <= 1'b0;
            ppu_writedata_q <= '0;
            ppu_address_q   <= '0;
        end else begin
            state_q     <= state_d;
            ppu_write_q <= pop;
            count_q     <= count_q + CW'(push) - CW'(pop);
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop) begin
                rd_ptr_q                         <= rd_ptr_q + AW'(1);
                {ppu_address_q, ppu_writedata_q} <= mem_q[rd_ptr_q];
            end
            if (drop) overflow_q <= 1'b1;
        end
    end

`ifdef SPRITE_CMD_OVF_CNT_EN
    logic [7:0] ovf_count_q;

    always_ff @(posedge clk) begin
        if (reset)                              ovf_count_q <= '0;
        else if (drop && ovf_count_q != 8'hff)  ovf_count_q <= ovf_count_q + 8'd1;
    end

    assign ovf_count = ovf_count_q;
`endif

    assign ppu_write     = ppu_write_q;
    assign ppu_writedata = ppu_writedata_q;
    assign ppu_address   = ppu_address_q;
    assign fifo_count    = count_q;
    assign overflow      = overflow_q;

endmodule
